// File: rtl/mem_pkg.sv
// Shared definitions for the memory pipeline stage: size codes, control-word bit
// positions, FSM states and the natural-alignment check.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam int LOAD_INSTR  = 9;
    localparam int RF_ENABLE   = 8;
    localparam int TA_INSTR    = 7;
    localparam int MEM_SIZE_HI = 6;
    localparam int MEM_SIZE_LO = 5;
    localparam int MEM_RW      = 4;
    localparam int MEM_SE      = 3;
    localparam int MEM_ENABLE  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Doubleword is only legal on a 64-bit datapath; elsewhere it is a trap.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lsb,
                                        input logic wide);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return lsb[0] == 1'b0;
            SZ_WORD: return lsb[1:0] == 2'b00;
            default: return wide && (lsb == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data lane select plus sign/zero extension; also used by the
// cache fill path.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]              rdata,
    input  logic [$clog2(DATA_W/8)-1:0]    offset,
    input  logic [1:0]                     size,
    input  logic                           se,
    output logic [DATA_W-1:0]              data
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] word_ext;

    assign shifted = rdata >> {offset, 3'b000};

    if (DATA_W > 32) begin : g_wide
        assign word_ext = {{(DATA_W-32){se & shifted[31]}}, shifted[31:0]};
    end else begin : g_narrow
        assign word_ext = shifted;
    end

    always_comb begin
        data = shifted;
        case (size)
            SZ_BYTE: data = {{(DATA_W-8){se & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = {{(DATA_W-16){se & shifted[15]}}, shifted[15:0]};
            SZ_WORD: data = word_ext;
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: issues aligned loads/stores over an ack handshake, traps
// misaligned accesses and forwards write-back control to the MEM/WB register.
module mem_stage_pipe
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [REG_W-1:0]    in_rd,
    input  logic                flush,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                wb_valid,
    output logic [2:0]          wb_ctrl,
    output logic [REG_W-1:0]    wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                misalign
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    state_e              state_reg;
    logic                kill_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [BE_W-1:0]     be_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                we_reg;
    logic [1:0]          size_reg;
    logic                se_reg;
    logic [2:0]          ctrl_reg;
    logic [REG_W-1:0]    rd_reg;
    logic                wb_valid_reg;
    logic [2:0]          wb_ctrl_reg;
    logic [REG_W-1:0]    wb_rd_reg;
    logic [DATA_W-1:0]   wb_data_reg;
    logic                misalign_reg;

    logic [1:0]          in_size;
    logic [OFF_W-1:0]    in_off;
    logic [3:0]          nbytes;
    logic [BE_W-1:0]     be_next;
    logic [DATA_W-1:0]   wdata_next;
    logic                aligned;
    logic [DATA_W-1:0]   load_data;
    logic                unused_ctrl;

    assign in_size     = in_ctrl[MEM_SIZE_HI:MEM_SIZE_LO];
    assign in_off      = in_addr[OFF_W-1:0];
    assign nbytes      = 4'd1 << in_size;
    assign wdata_next  = in_wdata << {in_off, 3'b000};
    assign aligned     = is_aligned(in_size, 3'(in_off), DATA_W == 64);
    assign unused_ctrl = ^{in_ctrl[CTRL_W-1:10], in_ctrl[1:0]};

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
        assign be_next[gi] = (gi >= int'(in_off)) && (gi < int'(in_off) + int'(nbytes));
    end

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata  (mem_rdata),
        .offset (addr_reg[OFF_W-1:0]),
        .size   (size_reg),
        .se     (se_reg),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            kill_reg     <= 1'b0;
            addr_reg     <= '0;
            mem_addr_reg <= '0;
            be_reg       <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
            size_reg     <= '0;
            se_reg       <= 1'b0;
            ctrl_reg     <= '0;
            rd_reg       <= '0;
            wb_valid_reg <= 1'b0;
            wb_ctrl_reg  <= '0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
            misalign_reg <= 1'b0;
        end else begin
            wb_valid_reg <= 1'b0;
            misalign_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && !flush) begin
                        if (!in_ctrl[MEM_ENABLE]) begin
                            wb_valid_reg <= 1'b1;
                            wb_ctrl_reg  <= in_ctrl[LOAD_INSTR:TA_INSTR];
                            wb_rd_reg    <= in_rd;
                            wb_data_reg  <= DATA_W'(in_addr);
                        end else if (!aligned) begin
                            misalign_reg <= 1'b1;
                        end else begin
                            state_reg    <= ST_BUSY;
                            kill_reg     <= 1'b0;
                            addr_reg     <= in_addr;
                            mem_addr_reg <= {in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                            be_reg       <= be_next;
                            wdata_reg    <= wdata_next;
                            we_reg       <= in_ctrl[MEM_RW];
                            size_reg     <= in_size;
                            se_reg       <= in_ctrl[MEM_SE];
                            ctrl_reg     <= in_ctrl[LOAD_INSTR:TA_INSTR];
                            rd_reg       <= in_rd;
                        end
                    end
                end
                ST_BUSY: begin
                    if (flush) kill_reg <= 1'b1;
                    // The bus access always runs to completion; a flush only drops its result.
                    if (mem_ack) begin
                        state_reg    <= ST_IDLE;
                        kill_reg     <= 1'b0;
                        wb_valid_reg <= !(kill_reg || flush);
                        wb_ctrl_reg  <= ctrl_reg;
                        wb_rd_reg    <= rd_reg;
                        wb_data_reg  <= we_reg ? DATA_W'(addr_reg) : load_data;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign stall     = (state_reg == ST_BUSY);
    assign mem_req   = (state_reg == ST_BUSY);
    assign mem_we    = we_reg && (state_reg == ST_BUSY);
    assign mem_be    = (state_reg == ST_BUSY) ? be_reg : '0;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = wdata_reg;
    assign wb_valid  = wb_valid_reg;
    assign wb_ctrl   = wb_ctrl_reg;
    assign wb_rd     = wb_rd_reg;
    assign wb_data   = wb_data_reg;
    assign misalign  = misalign_reg;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe with hand-computed expectations; a bench-side
// memory responder raises mem_ack after a chosen number of BUSY cycles.
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [17:0] in_ctrl;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        flush;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [2:0]  wb_ctrl;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_rd     (in_rd),
        .flush     (flush),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .wb_valid  (wb_valid),
        .wb_ctrl   (wb_ctrl),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .misalign  (misalign)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] mk_ctrl(input logic ld, input logic rf, input logic ta,
                                            input logic [1:0] sz, input logic rw,
                                            input logic se, input logic en);
        logic [17:0] c;
        c = '0;
        c[9] = ld; c[8] = rf; c[7] = ta; c[6:5] = sz; c[4] = rw; c[3] = se; c[2] = en;
        return c;
    endfunction

    // One memory access: accept, k+1 BUSY cycles with ack on the last, then write-back.
    task automatic access(input string tag, input logic [17:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int k,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_wb,
                          input int flush_at);
        in_valid = 1'b1; in_ctrl = ctrl; in_addr = addr; in_wdata = wdata; in_rd = rd;
        check({tag, "_accept_stall"}, stall, 0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i <= k; i++) begin
            flush = (i == flush_at);
            if (i == k) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end
            check({tag, "_stall"}, stall, 1);
            check({tag, "_req"}, mem_req, 1);
            check({tag, "_wbv_busy"}, wb_valid, 0);
            if (i == 0) begin
                check({tag, "_be"}, mem_be, exp_be);
                check({tag, "_we"}, mem_we, ctrl[4]);
                check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
                check({tag, "_wdata"}, mem_wdata, exp_wdata);
            end
            step();
        end
        mem_ack = 1'b0; flush = 1'b0; mem_rdata = 32'h0;
        check({tag, "_stall_done"}, stall, 0);
        check({tag, "_req_done"}, mem_req, 0);
        if (flush_at >= 0) begin
            check({tag, "_wbv_killed"}, wb_valid, 0);
        end else begin
            check({tag, "_wbv"}, wb_valid, 1);
            check({tag, "_wb_ctrl"}, wb_ctrl, ctrl[9:7]);
            check({tag, "_wb_rd"}, wb_rd, rd);
            check({tag, "_wb_data"}, wb_data, exp_wb);
        end
        $display("access %s addr=%h k=%0d wb_valid=%0d wb_data=%h", tag, addr, k, wb_valid, wb_data);
    endtask

    task automatic passthru(input string tag, input logic [31:0] addr, input logic [4:0] rd);
        in_valid = 1'b1; in_ctrl = mk_ctrl(0, 1, 0, 2'b00, 0, 0, 0) | 18'h3FC03;
        in_addr = addr; in_rd = rd;
        check({tag, "_req_now"}, mem_req, 0);
        step();
        in_valid = 1'b0;
        check({tag, "_wbv"}, wb_valid, 1);
        check({tag, "_wb_data"}, wb_data, addr);
        check({tag, "_wb_rd"}, wb_rd, rd);
        check({tag, "_wb_ctrl"}, wb_ctrl, 3'b010);
        check({tag, "_req"}, mem_req, 0);
        step();
        check({tag, "_pulse"}, wb_valid, 0);
        $display("passthru %s addr=%h rd=%0d", tag, addr, rd);
    endtask

    task automatic trap(input string tag, input logic [1:0] sz, input logic [31:0] addr);
        in_valid = 1'b1; in_ctrl = mk_ctrl(1, 1, 0, sz, 0, 0, 1); in_addr = addr; in_rd = 5'd9;
        step();
        in_valid = 1'b0;
        check({tag, "_misalign"}, misalign, 1);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_wbv"}, wb_valid, 0);
        step();
        check({tag, "_misalign_pulse"}, misalign, 0);
        check({tag, "_req_after"}, mem_req, 0);
        $display("trap %s size=%0d addr=%h", tag, sz, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_addr = '0; in_wdata = '0;
        in_rd = '0; flush = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_stall", stall, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_be", mem_be, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_wb_ctrl", wb_ctrl, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_misalign", misalign, 0);
        $display("reset released");

        passthru("pass", 32'h1234, 5'd7);

        access("lb_signed", mk_ctrl(1, 1, 0, 2'b00, 0, 1, 1), 32'h103, 32'h0, 5'd4, 3,
               32'h8012_3456, 4'b1000, 32'h0, 32'hFFFF_FF80, -1);
        access("sh", mk_ctrl(0, 0, 0, 2'b01, 1, 0, 1), 32'h102, 32'h0000_BEEF, 5'd0, 0,
               32'h0, 4'b1100, 32'hBEEF_0000, 32'h102, -1);
        step();
        check("sh_pulse", wb_valid, 0);
        access("lhu", mk_ctrl(1, 1, 0, 2'b01, 0, 0, 1), 32'h102, 32'h0, 5'd5, 1,
               32'h8001_7777, 4'b1100, 32'h0, 32'h0000_8001, -1);
        access("lbu", mk_ctrl(1, 1, 0, 2'b00, 0, 0, 1), 32'h101, 32'h0, 5'd6, 0,
               32'h1122_F344, 4'b0010, 32'h0, 32'h0000_00F3, -1);
        access("lw", mk_ctrl(1, 1, 1, 2'b10, 0, 1, 1), 32'h200, 32'h0, 5'd8, 2,
               32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF, -1);
        access("sb", mk_ctrl(0, 0, 0, 2'b00, 1, 0, 1), 32'h301, 32'h0000_00A5, 5'd0, 1,
               32'h0, 4'b0010, 32'h0000_A500, 32'h301, -1);

        trap("mis_word", 2'b10, 32'h101);
        trap("mis_half", 2'b01, 32'h103);
        trap("mis_dword", 2'b11, 32'h100);

        access("flush", mk_ctrl(1, 1, 0, 2'b10, 0, 0, 1), 32'h400, 32'h0, 5'd2, 2,
               32'h1234_5678, 4'b1111, 32'h0, 32'h0, 0);
        passthru("after_flush", 32'h55, 5'd3);

        // Flush in IDLE drops the input.
        in_valid = 1'b1; flush = 1'b1; in_ctrl = mk_ctrl(0, 1, 0, 2'b00, 0, 0, 0);
        in_addr = 32'h66; in_rd = 5'd1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_wbv", wb_valid, 0);
        $display("idle flush dropped input");

        // Reset in the second BUSY cycle.
        in_valid = 1'b1; in_ctrl = mk_ctrl(1, 1, 0, 2'b10, 0, 0, 1); in_addr = 32'h500; in_rd = 5'd11;
        step();
        in_valid = 1'b0;
        check("rstmid_req1", mem_req, 1);
        step();
        check("rstmid_req2", mem_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmid_req", mem_req, 0);
        check("rstmid_stall", stall, 0);
        check("rstmid_be", mem_be, 0);
        check("rstmid_addr", mem_addr, 0);
        check("rstmid_wb_data", wb_data, 0);
        check("rstmid_wb_rd", wb_rd, 0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0;
        check("late_ack_wbv", wb_valid, 0);
        check("late_ack_req", mem_req, 0);
        check("late_ack_stall", stall, 0);
        $display("reset mid-access and late ack handled");

        passthru("final", 32'hABC, 5'd31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
